mux_scan_ctrl: RTL

- Select sequencer and sample assembler that sits directly upstream and downstream of the team's 8:1 mux.
- Drives the mux select `sel` through channels 0..7, waits a programmable settle time on each, and samples the mux output `d_in`.
- Assembles the eight samples into one parallel word, so a registered snapshot of the mux's 8 inputs is delivered with start/busy/valid handshaking.
- Supports single-shot scans and continuous back-to-back scans.

---
 rtl/mux_scan_ctrl_pkg.sv | 33 +++
 rtl/mux_scan_ctrl_dwell_counter.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux select sequencer / sample assembler.
package mux_scan_ctrl_pkg;

    // Default geometry of the scanned mux.
    localparam int NCH_DEF   = 8;
    localparam int SEL_W_DEF = 3;

    // Dwell counter geometry: 4 bits is enough for the largest legal dwell.
    localparam int CNT_W     = 4;
    localparam int DWELL_MAX = 15;

    // Controller states, exposed on the state output for observation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Terminal count for a given dwell. The dwell is clamped into 1..DWELL_MAX
    // so an out-of-range parameter can never push the counter past its width.
    function automatic logic [CNT_W-1:0] dwell_tc(input int dwell);
        int d;
        d = dwell;
        if (d < 1) begin
            d = 1;
        end
        if (d > DWELL_MAX) begin
            d = DWELL_MAX;
        end
        return CNT_W'(d - 1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_counter.sv
// Per-channel dwell counter. Counts cycles while enabled and raises tc on the
// cycle in which the count equals DWELL-1; the count wraps to 0 on that edge
// so the next channel starts from a clean count.
module mux_scan_ctrl_dwell_counter
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = dwell_tc(DWELL);

    logic [CNT_W-1:0] count;

    // Terminal count only matters while the counter is actually running.
    assign tc = en && (count == TC_VAL);

    // Count while enabled; hold at zero whenever disabled so entry into a
    // scan always starts from a zero count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en) begin
            count <= '0;
        end else if (count == TC_VAL) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer and sample assembler around an 8:1 mux.
//
// Handshake: a scan is requested by start (only looked at in IDLE, ignored
// otherwise, never queued). busy is high from the start edge until the edge
// that leaves DONE for IDLE; in continuous mode it never drops between scans.
// valid is a single-cycle pulse, coincident with the DONE state, in the cycle
// where word_out first shows the new scan. abort (or reset) drops the scan in
// flight without any valid and without touching word_out.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             d_in,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   word_out,
    output logic             valid,
    output logic             busy,
    output state_t           state
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NCH - 1);

    logic [NCH-1:0] shadow;
    logic [NCH-1:0] captured;
    logic           cnt_en;
    logic           tc;

    // The counter only runs in SCAN; an abort clears it on the same edge that
    // the FSM returns to IDLE.
    assign cnt_en = (state == SCAN) && !abort;

    mux_scan_ctrl_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .tc    (tc)
    );

    // Shadow contents with the current mux output merged at the current
    // channel: what the shadow becomes on a sampling edge, and on the last
    // channel the word that is published.
    always_comb begin
        captured      = shadow;
        captured[sel] = d_in;
    end

    // Scan FSM with select, shadow and output word registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            shadow   <= '0;
            word_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    sel  <= '0;
                    busy <= 1'b0;
                    if (start && !abort) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        shadow <= '0;
                    end
                end

                SCAN: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        sel    <= '0;
                        shadow <= '0;
                    end else if (tc) begin
                        shadow <= captured;
                        if (sel == LAST_SEL) begin
                            // Last channel: publish the word on the same
                            // edge that enters DONE.
                            state    <= DONE;
                            word_out <= captured;
                            valid    <= 1'b1;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end
                end

                DONE: begin
                    sel    <= '0;
                    shadow <= '0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cont) begin
                        // Back-to-back scan: no idle cycle, busy stays high.
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    sel    <= '0;
                    shadow <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
